flash_loader: RTL
=================

# flash_loader

Boot-time copier between the SPI flash pins and the RAMIO port. After reset and a `start` request it issues a flash READ (0x03) command and streams `FLASH_TRANSFER_BYTES` bytes from flash. It writes them as little-endian 32-bit words into RAMIO starting at `RAM_DEST_ADDR`, then raises `done` so the core can be released onto a populated RAM.

## Interface

Parameters:
- `FLASH_TRANSFER_BYTES`, 4096: bytes to copy; nonzero multiple of 4.
- `FLASH_START_ADDR`, 24'h000000: first flash byte address.
- `RAM_DEST_ADDR`, 32'h00000000: first RAMIO byte address.
- `CLK_HALF_PERIOD`, 1: `clk` cycles per `flash_clk` phase; ≥1.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock (`br_clk_out` domain).
- `rst` in 1: synchronous active-high reset.
- `start` in 1: level; sampled in IDLE only.
- `busy` out 1: high from start acceptance until `done`.
- `done` out 1: sticky high after the last RAMIO write completes; cleared only by `rst`.
- `flash_clk` out 1: SPI clock, mode 0, idles low.
- `flash_mosi` out 1: SPI data out.
- `flash_miso` in 1: SPI data in.
- `flash_cs` out 1: chip select, active low.
- `ramio_enable` out 1: one-cycle write request.
- `ramio_write_type` out 2: 2'b11 (word) during a request; 2'b00 otherwise.
- `ramio_read_type` out 3: constant 3'b000.
- `ramio_address` out 32: write byte address.
- `ramio_data_in` out 32: write data.
- `ramio_busy` in 1: RAMIO busy.

## Operation

- Reset values: `flash_cs`=1, `flash_clk`=0, `flash_mosi`=0, `ramio_enable`=0, `ramio_write_type`=0, `ramio_address`=0, `ramio_data_in`=0, `busy`=0, `done`=0. State is IDLE.
- IDLE: when `start`=1 and `done`=0, set `flash_cs`=0 and `busy`=1, load the 32-bit shift register with {8'h03, `FLASH_START_ADDR`}, and go to CMD.
- CMD: shift out 32 bits MSB first. `flash_mosi` changes only while `flash_clk` is low. After bit 0 falls, go to READ.
- READ: clock in 32 bits. Each byte arrives MSB first. Byte k of the word goes to bits [8k+7:8k], so the first flash byte lands in [7:0]. After 32 bits, go to WRITE.
- WRITE: `flash_clk` is held low and `flash_cs` stays low, so the flash read streams continuously. Wait for `ramio_busy`=0, then assert `ramio_enable` for exactly one cycle with the address and data. Go to WAIT.
- WAIT: ignore `ramio_busy` for one cycle, then wait for `ramio_busy`=0. Advance the address by 4 and decrement the word count. If words remain, go to READ; otherwise go to DONE.
- DONE: `flash_cs`=1, `busy`=0, `done`=1. Stay in DONE until reset.
- Word count width: $clog2(FLASH_TRANSFER_BYTES/4+1). Address arithmetic wraps modulo 2^32.
- `rst` at any point, including mid-transfer, returns to the reset values on the next edge. `flash_cs` rises immediately, which aborts the flash command. A new `start` restarts from `FLASH_START_ADDR`.
- `start` is ignored outside IDLE.

## Timing

- One SPI bit takes 2·`CLK_HALF_PERIOD` `clk` cycles.
- `flash_clk` rises after the low phase. `flash_miso` is sampled on the `clk` edge that drives `flash_clk` 1→0.
- CMD phase: 64·`CLK_HALF_PERIOD` cycles. READ phase: 64·`CLK_HALF_PERIOD` cycles per word.
- With `CLK_HALF_PERIOD`=1 and an idle RAMIO, the first `ramio_enable` comes at most 130 cycles after `start` is accepted.
- `flash_cs` falls 1 cycle after `start` is accepted. No `flash_clk` edge occurs while `flash_cs`=1.
- `done` rises on the cycle after the final WAIT exit.

## Configuration

- `FLASH_LOADER_CHECKSUM_EN` defined:
  - Adds output `checksum` (32 bits), the running sum modulo 2^32 of every word written.
  - `checksum` updates on each `ramio_enable` cycle and resets to 0.
- Not defined: no `checksum` port and no adder.

## Structure

- `flash_loader_pkg` holds:
  - the state enum: IDLE, CMD, READ, WRITE, WAIT, DONE;
  - `FLASH_CMD_READ`=8'h03;
  - RAMIO encodings `RAMIO_WRITE_NONE`=2'b00, `RAMIO_WRITE_WORD`=2'b11, `RAMIO_READ_NONE`=3'b000.
- One sub-module, `flash_spi_shift`, owns the bit-level work:
  - `flash_clk` phase generation;
  - the 32-bit shift register;
  - `bit_done`/`word_done` strobes.
- The top FSM handles sequencing, RAMIO handshake and counters.

## Test plan

- Reset hold for 5 cycles → `flash_cs`=1, `flash_clk`=0, `ramio_enable`=0, `busy`=0, `done`=0.
- `FLASH_START_ADDR`=24'h012345, `start`=1 → the first 32 MOSI bits captured on `flash_clk` rising edges equal 32'h03012345.
- `FLASH_TRANSFER_BYTES`=8, flash model returns 01..08 → exactly two writes: (0x00000000, 0x04030201) then (0x00000004, 0x08070605). `done`=1 and `flash_cs`=1 after the second write.
- `ramio_busy` held high for 20 cycles after the first enable → no second enable and `flash_clk` stays low throughout. Streaming resumes after busy falls, and the data is still 0x08070605.
- `rst` pulsed in the middle of the second word → `flash_cs`=1 next cycle, `ramio_enable`=0. A new `start` again sends 0x03 plus the start address and rewrites address 0x00000000.
- `FLASH_LOADER_CHECKSUM_EN` with the 8-byte case → `checksum`=0x0C0A0806 at `done`.

Source files
------------

// File: rtl/flash_loader_pkg.sv
// flash_loader_pkg: shared constants for the boot-time flash copier.
// Holds the FSM state encoding, the SPI READ opcode and the RAMIO access encodings.
package flash_loader_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CMD   = 3'd1;
  localparam logic [2:0] ST_READ  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_WAIT  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  localparam logic [7:0] FLASH_CMD_READ = 8'h03;

  localparam logic [1:0] RAMIO_WRITE_NONE = 2'b00;
  localparam logic [1:0] RAMIO_WRITE_WORD = 2'b11;
  localparam logic [2:0] RAMIO_READ_NONE  = 3'b000;

endpackage

// File: rtl/flash_loader_if.sv
// flash_loader_if: SPI flash pins plus the RAMIO write port driven by the loader.
// master = the loader, slave = the flash device / RAM side.
interface flash_loader_if;

  logic        flash_clk;
  logic        flash_mosi;
  logic        flash_miso;
  logic        flash_cs;
  logic        ramio_enable;
  logic [1:0]  ramio_write_type;
  logic [2:0]  ramio_read_type;
  logic [31:0] ramio_address;
  logic [31:0] ramio_data_in;
  logic        ramio_busy;

  modport master (
    output flash_clk, flash_mosi, flash_cs,
    output ramio_enable, ramio_write_type, ramio_read_type, ramio_address, ramio_data_in,
    input  flash_miso, ramio_busy
  );

  modport slave (
    input  flash_clk, flash_mosi, flash_cs,
    input  ramio_enable, ramio_write_type, ramio_read_type, ramio_address, ramio_data_in,
    output flash_miso, ramio_busy
  );

endinterface

// File: rtl/flash_spi_shift.sv
// flash_spi_shift: SPI mode-0 bit engine for the flash loader.
// Generates flash_clk (low phase first), shifts a 32-bit register MSB first,
// samples miso on the clk edge that drops flash_clk, and flags bit/word ends.
module flash_spi_shift #(
  parameter int CLK_HALF_PERIOD = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic        run,
  input  logic        miso,
  output logic        flash_clk,
  output logic        mosi,
  output logic [31:0] shift_data,
  output logic        bit_done,
  output logic        word_done
);

  localparam int CW = (CLK_HALF_PERIOD > 1) ? $clog2(CLK_HALF_PERIOD) : 1;
  localparam logic [CW-1:0] PHASE_LAST = CW'(CLK_HALF_PERIOD - 1);

  logic [CW-1:0] phase_cnt;
  logic [4:0]    bit_cnt;
  logic          sending;
  logic          phase_end;

  assign phase_end = run && (phase_cnt == PHASE_LAST);
  assign bit_done  = phase_end && flash_clk;
  assign word_done = bit_done && (bit_cnt == 5'd31);
  assign mosi      = sending & shift_data[31];

  // Phase timing, SPI clock toggling and the shift register; idles with flash_clk low
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_cnt  <= '0;
      bit_cnt    <= '0;
      flash_clk  <= 1'b0;
      shift_data <= '0;
      sending    <= 1'b0;
    end else if (load) begin
      phase_cnt  <= '0;
      bit_cnt    <= '0;
      flash_clk  <= 1'b0;
      shift_data <= load_data;
      sending    <= 1'b1;
    end else if (run) begin
      if (phase_end) begin
        phase_cnt <= '0;
        flash_clk <= ~flash_clk;
        if (flash_clk) begin
          shift_data <= {shift_data[30:0], miso};
          bit_cnt    <= bit_cnt + 5'd1;
          if (word_done) begin
            sending <= 1'b0;
          end
        end
      end else begin
        phase_cnt <= phase_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/flash_loader.sv
// flash_loader: copies FLASH_TRANSFER_BYTES from SPI flash into RAMIO as
// little-endian words, then raises a sticky done.
// Optional feature macro: FLASH_LOADER_CHECKSUM_EN adds a 32-bit checksum output.
module flash_loader
  import flash_loader_pkg::*;
#(
  parameter int          FLASH_TRANSFER_BYTES = 4096,
  parameter logic [23:0] FLASH_START_ADDR     = 24'h000000,
  parameter logic [31:0] RAM_DEST_ADDR        = 32'h00000000,
  parameter int          CLK_HALF_PERIOD      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
`ifdef FLASH_LOADER_CHECKSUM_EN
  output logic [31:0] checksum,
`endif
  flash_loader_if.master bus
);

  localparam int WORDS   = FLASH_TRANSFER_BYTES / 4;
  localparam int COUNT_W = $clog2(WORDS + 1);
  localparam logic [COUNT_W-1:0] WORD_TOTAL = COUNT_W'(WORDS);
  localparam logic [COUNT_W-1:0] LAST_WORD  = COUNT_W'(1);

  logic [2:0]         state;
  logic               cs_q;
  logic               enable_q;
  logic [1:0]         write_type_q;
  logic [31:0]        address_q;
  logic [31:0]        data_q;
  logic [31:0]        next_addr;
  logic [COUNT_W-1:0] words_left;
  logic               wait_first;

  logic               spi_load;
  logic               spi_run;
  logic               spi_clk;
  logic               spi_mosi;
  logic [31:0]        spi_data;
  logic               bit_done;
  logic               word_done;
  logic               word_end;
  logic [31:0]        le_word;

  assign spi_load = (state == ST_IDLE) && start && !done;
  assign spi_run  = (state == ST_CMD) || (state == ST_READ);
  assign word_end = bit_done && word_done;
  assign le_word  = {spi_data[7:0], spi_data[15:8], spi_data[23:16], spi_data[31:24]};

  flash_spi_shift #(
    .CLK_HALF_PERIOD(CLK_HALF_PERIOD)
  ) u_shift (
    .clk        (clk),
    .rst        (rst),
    .load       (spi_load),
    .load_data  ({FLASH_CMD_READ, FLASH_START_ADDR}),
    .run        (spi_run),
    .miso       (bus.flash_miso),
    .flash_clk  (spi_clk),
    .mosi       (spi_mosi),
    .shift_data (spi_data),
    .bit_done   (bit_done),
    .word_done  (word_done)
  );

  assign bus.flash_clk        = spi_clk;
  assign bus.flash_mosi       = spi_mosi;
  assign bus.flash_cs         = cs_q;
  assign bus.ramio_enable     = enable_q;
  assign bus.ramio_write_type = write_type_q;
  assign bus.ramio_read_type  = RAMIO_READ_NONE;
  assign bus.ramio_address    = address_q;
  assign bus.ramio_data_in    = data_q;

  // Transfer sequencing: command, per-word read, RAMIO write handshake, completion
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cs_q         <= 1'b1;
      enable_q     <= 1'b0;
      write_type_q <= RAMIO_WRITE_NONE;
      address_q    <= '0;
      data_q       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      next_addr    <= '0;
      words_left   <= '0;
      wait_first   <= 1'b0;
    end else begin
      enable_q     <= 1'b0;
      write_type_q <= RAMIO_WRITE_NONE;
      case (state)
        ST_IDLE: begin
          if (start && !done) begin
            cs_q       <= 1'b0;
            busy       <= 1'b1;
            next_addr  <= RAM_DEST_ADDR;
            words_left <= WORD_TOTAL;
            state      <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (word_end) begin
            state <= ST_READ;
          end
        end
        ST_READ: begin
          if (word_end) begin
            state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (!bus.ramio_busy) begin
            enable_q     <= 1'b1;
            write_type_q <= RAMIO_WRITE_WORD;
            address_q    <= next_addr;
            data_q       <= le_word;
            wait_first   <= 1'b1;
            state        <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_first) begin
            wait_first <= 1'b0;
          end else if (!bus.ramio_busy) begin
            next_addr  <= next_addr + 32'd4;
            words_left <= words_left - LAST_WORD;
            if (words_left == LAST_WORD) begin
              cs_q  <= 1'b1;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              state <= ST_READ;
            end
          end
        end
        ST_DONE: begin
          state <= ST_DONE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef FLASH_LOADER_CHECKSUM_EN
  // Running modulo-2^32 sum of every word handed to RAMIO
  always_ff @(posedge clk) begin
    if (rst) begin
      checksum <= '0;
    end else if (enable_q) begin
      checksum <= checksum + data_q;
    end
  end
`else
  // Default build carries no checksum register or adder
`endif

endmodule
